// File: rtl/register_file_mp_if.sv
// register_file_mp_if
// Bundles the read ports, both write ports, the debug-dump handshake and the
// flattened state view of register_file_mp. The master modport belongs to the
// core/monitor side; the slave modport belongs to the register file itself.
// Packing: read port p uses rd_addr[p*A +: A] and rd_data[p*N +: N];
// register i appears at full_register_file[i*N +: N].

interface register_file_mp_if #(
    parameter int N  = 32,
    parameter int A  = 5,
    parameter int NR = 2
);
    localparam int DEPTH = 2 ** A;

    // Read ports
    logic [NR*A-1:0]    rd_addr;
    logic [NR*N-1:0]    rd_data;

    // Write port 0
    logic [A-1:0]       wr_addr0;
    logic [N-1:0]       wr_data0;
    logic               wr_ena0;

    // Write port 1 (wins on an address collision)
    logic [A-1:0]       wr_addr1;
    logic [N-1:0]       wr_data1;
    logic               wr_ena1;

    // Debug-dump engine
    logic               dump_req;
    logic               dump_busy;
    logic               dump_valid;
    logic [A-1:0]       dump_index;
    logic [N-1:0]       dump_data;
    logic               dump_done;

    // Flattened register contents
    logic [DEPTH*N-1:0] full_register_file;

    modport master (
        output rd_addr,
        output wr_addr0, wr_data0, wr_ena0,
        output wr_addr1, wr_data1, wr_ena1,
        output dump_req,
        input  rd_data,
        input  dump_busy, dump_valid, dump_index, dump_data, dump_done,
        input  full_register_file
    );

    modport slave (
        input  rd_addr,
        input  wr_addr0, wr_data0, wr_ena0,
        input  wr_addr1, wr_data1, wr_ena1,
        input  dump_req,
        output rd_data,
        output dump_busy, dump_valid, dump_index, dump_data, dump_done,
        output full_register_file
    );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp
// Parametrised multi-port register file: NR combinational read ports, two
// write ports (port 1 wins when both hit the same address), an optional
// hardwired-zero register 0, and a debug-dump engine that walks every register
// out one per cycle without disturbing the read/write ports.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> read ports forward same-cycle write data (write-first),
//                port 1 data taking precedence over port 0.
//   undefined -> reads see pre-write contents; new data appears next cycle.
// The dump stream and full_register_file always show stored contents.

module register_file_mp #(
    parameter int N             = 32,
    parameter int A             = 5,
    parameter int NR            = 2,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_mp_if.slave  bus
);

    localparam int         DEPTH      = 2 ** A;
    localparam logic [A-1:0] LAST_INDEX = {A{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    // Storage and the zero-masked view every consumer reads from
    logic [N-1:0]      regs [DEPTH];
    logic [N-1:0]      view [DEPTH];

    // Write qualification after the zero-register rule
    logic              write_ok0;
    logic              write_ok1;

    // Read path
    logic [NR*N-1:0]   rd_data_int;

    // Dump engine state and registered outputs
    dump_state_t       dump_state;
    logic              dump_busy_q;
    logic              dump_valid_q;
    logic              dump_done_q;
    logic [A-1:0]      dump_index_q;

    // Flattened state
    logic [DEPTH*N-1:0] flat_state;

    // A write to register 0 is dropped entirely when it is hardwired to zero
    assign write_ok0 = bus.wr_ena0 && !((HARDWIRE_ZERO != 0) && (bus.wr_addr0 == '0));
    assign write_ok1 = bus.wr_ena1 && !((HARDWIRE_ZERO != 0) && (bus.wr_addr1 == '0));

    // Register storage: port 1 is applied second so it overrides port 0 on a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write_ok0) begin
                regs[bus.wr_addr0] <= bus.wr_data0;
            end
            if (write_ok1) begin
                regs[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    // Zero-masked copy of the storage so register 0 reads as 0 everywhere
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            view[i] = regs[i];
        end
        if (HARDWIRE_ZERO != 0) begin
            view[0] = '0;
        end
    end

    // Combinational read ports, optionally forwarding same-cycle write data
    always_comb begin
        rd_data_int = '0;
        for (int p = 0; p < NR; p++) begin
            rd_data_int[p*N +: N] = view[bus.rd_addr[p*A +: A]];
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_ena1 && (bus.wr_addr1 == bus.rd_addr[p*A +: A])) begin
                rd_data_int[p*N +: N] = bus.wr_data1;
            end else if (bus.wr_ena0 && (bus.wr_addr0 == bus.rd_addr[p*A +: A])) begin
                rd_data_int[p*N +: N] = bus.wr_data0;
            end
            if ((HARDWIRE_ZERO != 0) && (bus.rd_addr[p*A +: A] == '0)) begin
                rd_data_int[p*N +: N] = '0;
            end
`endif
        end
    end

    assign bus.rd_data = rd_data_int;

    // Dump engine: IDLE waits for a request, RUN emits one register per cycle,
    // DONE raises the completion pulse; requests outside IDLE are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_state   <= IDLE;
            dump_busy_q  <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_index_q <= '0;
        end else begin
            case (dump_state)
                IDLE: begin
                    dump_done_q  <= 1'b0;
                    dump_index_q <= '0;
                    if (bus.dump_req) begin
                        dump_state   <= RUN;
                        dump_valid_q <= 1'b1;
                        dump_busy_q  <= 1'b1;
                    end else begin
                        dump_valid_q <= 1'b0;
                        dump_busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (dump_index_q == LAST_INDEX) begin
                        dump_state   <= DONE;
                        dump_valid_q <= 1'b0;
                        dump_done_q  <= 1'b1;
                    end else begin
                        dump_index_q <= dump_index_q + A'(1);
                    end
                end
                DONE: begin
                    dump_state   <= IDLE;
                    dump_done_q  <= 1'b0;
                    dump_busy_q  <= 1'b0;
                    dump_index_q <= '0;
                end
                default: begin
                    dump_state   <= IDLE;
                    dump_busy_q  <= 1'b0;
                    dump_valid_q <= 1'b0;
                    dump_done_q  <= 1'b0;
                    dump_index_q <= '0;
                end
            endcase
        end
    end

    assign bus.dump_busy  = dump_busy_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_done  = dump_done_q;
    assign bus.dump_index = dump_index_q;

    // Dump data is the live stored word, so a not-yet-dumped register shows
    // any write that landed before its turn; it is held at 0 outside RUN
    assign bus.dump_data  = dump_valid_q ? view[dump_index_q] : '0;

    // Flattened state for the monitor, register i in slice i
    always_comb begin
        flat_state = '0;
        for (int i = 0; i < DEPTH; i++) begin
            flat_state[i*N +: N] = view[i];
        end
    end

    assign bus.full_register_file = flat_state;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
// Self-checking bench for register_file_mp with default parameters
// (N=32, A=5, NR=2, HARDWIRE_ZERO=1). Read vectors come from a table; the
// dump stream is checked against a scoreboard queue filled from a reference
// model of the register contents.

module tb_register_file_mp;

    localparam int N     = 32;
    localparam int A     = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int NVEC  = 10;

    typedef struct packed {
        logic         e0;
        logic [A-1:0] a0;
        logic [N-1:0] d0;
        logic         e1;
        logic [A-1:0] a1;
        logic [N-1:0] d1;
        logic [A-1:0] r0;
        logic [A-1:0] r1;
        logic [N-1:0] x0;
        logic [N-1:0] x1;
    } vec_t;

    typedef struct packed {
        logic [A-1:0] idx;
        logic [N-1:0] data;
    } dump_exp_t;

    logic         clk;
    logic         rst;

    register_file_mp_if #(.N(N), .A(A), .NR(NR)) bus ();

    register_file_mp #(.N(N), .A(A), .NR(NR), .HARDWIRE_ZERO(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t         vecs [NVEC];
    logic [N-1:0] model_regs [DEPTH];
    logic [N-1:0] read_q [$];
    dump_exp_t    dump_q [$];

    int           vectors_applied = 0;
    int           miscompares     = 0;
    int           cycles;
    int           valid_count;
    int           done_count;
    logic         done_seen;
    dump_exp_t    exp_entry;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic modelWrite(input logic e, input logic [A-1:0] a, input logic [N-1:0] d);
        if (e && (a != '0)) begin
            model_regs[a] = d;
        end
    endtask

    task automatic clearWrites();
        bus.wr_ena0 = 1'b0;
        bus.wr_ena1 = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.wr_ena0  = v.e0;
        bus.wr_addr0 = v.a0;
        bus.wr_data0 = v.d0;
        bus.wr_ena1  = v.e1;
        bus.wr_addr1 = v.a1;
        bus.wr_data1 = v.d1;
        bus.rd_addr  = {v.r1, v.r0};
        read_q.push_back(v.x0);
        read_q.push_back(v.x1);
        modelWrite(v.e0, v.a0, v.d0);
        modelWrite(v.e1, v.a1, v.d1);
        #1;
        checkOutput("rd_port0", bus.rd_data[N-1:0], read_q.pop_front());
        checkOutput("rd_port1", bus.rd_data[2*N-1:N], read_q.pop_front());
    endtask

    task automatic checkFrf(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("%s_reg%0d", tag, i), bus.full_register_file[i*N +: N], model_regs[i]);
        end
    endtask

    initial begin
        // Read/write table: reads never alias a same-cycle write so the
        // expectations hold with or without write-first forwarding
        vecs[0] = '{1'b1, 5'd5,  32'hAAAA0000, 1'b1, 5'd6,  32'h0000BBBB, 5'd9,  5'd31, 32'h00000000, 32'h00000000};
        vecs[1] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h00000000, 5'd5,  5'd6,  32'hAAAA0000, 32'h0000BBBB};
        vecs[2] = '{1'b1, 5'd9,  32'h00000001, 1'b1, 5'd9,  32'h00000002, 5'd5,  5'd0,  32'hAAAA0000, 32'h00000000};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd7,  32'h12345678, 5'd9,  5'd5,  32'h00000002, 32'hAAAA0000};
        vecs[4] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h00000000, 5'd0,  5'd7,  32'h00000000, 32'h12345678};
        vecs[5] = '{1'b1, 5'd31, 32'h80000001, 1'b0, 5'd31, 32'h00000055, 5'd7,  5'd9,  32'h12345678, 32'h00000002};
        vecs[6] = '{1'b1, 5'd30, 32'hCAFEF00D, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd31, 5'd0,  32'h80000001, 32'h00000000};
        vecs[7] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h00000000, 5'd30, 5'd0,  32'hCAFEF00D, 32'h00000000};
        vecs[8] = '{1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd10, 32'h00000001, 5'd7,  5'd30, 32'h12345678, 32'hCAFEF00D};
        vecs[9] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  32'h00000000, 5'd10, 5'd6,  32'hA5A5A5A5, 32'h0000BBBB};

        for (int i = 0; i < DEPTH; i++) begin
            model_regs[i] = '0;
        end

        rst          = 1'b1;
        bus.rd_addr  = '0;
        bus.wr_addr0 = '0;
        bus.wr_data0 = '0;
        bus.wr_ena0  = 1'b0;
        bus.wr_addr1 = '0;
        bus.wr_data1 = '0;
        bus.wr_ena1  = 1'b0;
        bus.dump_req = 1'b0;

        // Reset state, with a write attempted while reset is held
        @(negedge clk);
        bus.wr_ena0  = 1'b1;
        bus.wr_addr0 = 5'd4;
        bus.wr_data0 = 32'h00000044;
        @(negedge clk);
        checkOutput("reset_dump_busy",  32'(bus.dump_busy),  0);
        checkOutput("reset_dump_valid", 32'(bus.dump_valid), 0);
        checkOutput("reset_dump_done",  32'(bus.dump_done),  0);
        checkOutput("reset_dump_index", 32'(bus.dump_index), 0);
        checkOutput("reset_dump_data",  bus.dump_data,       0);
        checkFrf("reset");
        clearWrites();
        rst = 1'b0;

        // Table-driven read/write vectors
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        // Same-cycle write and read of register 3
        @(negedge clk);
        bus.wr_ena0  = 1'b1;
        bus.wr_addr0 = 5'd3;
        bus.wr_data0 = 32'hDEADBEEF;
        bus.wr_ena1  = 1'b0;
        bus.rd_addr  = {5'd5, 5'd3};
        modelWrite(1'b1, 5'd3, 32'hDEADBEEF);
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_same_cycle", bus.rd_data[N-1:0], 32'hDEADBEEF);
`else
        checkOutput("bypass_same_cycle", bus.rd_data[N-1:0], 32'h00000000);
`endif
        @(negedge clk);
        clearWrites();
        #1;
        checkOutput("bypass_next_cycle", bus.rd_data[N-1:0], 32'hDEADBEEF);
        checkFrf("after_writes");

        // Preload reg i = i*3 using both ports
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.wr_ena0  = 1'b1;
            bus.wr_addr0 = A'(i);
            bus.wr_data0 = 32'(i * 3);
            bus.wr_ena1  = 1'b1;
            bus.wr_addr1 = A'(i + 16);
            bus.wr_data1 = 32'((i + 16) * 3);
            modelWrite(1'b1, A'(i), 32'(i * 3));
            modelWrite(1'b1, A'(i + 16), 32'((i + 16) * 3));
        end

        // Full dump with a mid-dump write and an ignored second request
        @(negedge clk);
        clearWrites();
        bus.dump_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            dump_q.push_back('{idx: A'(i), data: model_regs[i]});
        end
        @(negedge clk);
        bus.dump_req = 1'b0;
        cycles      = 0;
        valid_count = 0;
        done_seen   = 1'b0;
        while (!done_seen && cycles < 100) begin
            if (bus.dump_valid) begin
                if (dump_q.size() == 0) begin
                    checkOutput("dump_extra_word", 32'(bus.dump_index), 32'hFFFFFFFF);
                end else begin
                    exp_entry = dump_q.pop_front();
                    checkOutput($sformatf("dump_index_%0d", exp_entry.idx), 32'(bus.dump_index), 32'(exp_entry.idx));
                    checkOutput($sformatf("dump_data_%0d", exp_entry.idx), bus.dump_data, exp_entry.data);
                end
                valid_count++;
                if (bus.dump_index == 5'd5) begin
                    bus.wr_ena0  = 1'b1;
                    bus.wr_addr0 = 5'd20;
                    bus.wr_data0 = 32'hBEEF0020;
                    bus.wr_ena1  = 1'b1;
                    bus.wr_addr1 = 5'd2;
                    bus.wr_data1 = 32'h0BAD0002;
                    modelWrite(1'b1, 5'd20, 32'hBEEF0020);
                    modelWrite(1'b1, 5'd2, 32'h0BAD0002);
                    foreach (dump_q[k]) begin
                        if (dump_q[k].idx == 5'd20) begin
                            dump_q[k].data = 32'hBEEF0020;
                        end
                    end
                end
                if (bus.dump_index == 5'd10) begin
                    bus.dump_req = 1'b1;
                end
            end
            if (bus.dump_done) begin
                done_seen = 1'b1;
                checkOutput("dump_busy_in_done",  32'(bus.dump_busy),  1);
                checkOutput("dump_valid_in_done", 32'(bus.dump_valid), 0);
            end else begin
                @(negedge clk);
                cycles++;
                bus.dump_req = 1'b0;
                clearWrites();
            end
        end
        checkOutput("dump_done_seen",   32'(done_seen),    1);
        checkOutput("dump_valid_count", 32'(valid_count),  DEPTH);
        checkOutput("dump_queue_empty", 32'(dump_q.size()), 0);
        @(negedge clk);
        checkOutput("after_done_busy",  32'(bus.dump_busy),  0);
        checkOutput("after_done_done",  32'(bus.dump_done),  0);
        checkOutput("after_done_index", 32'(bus.dump_index), 0);
        repeat (3) @(negedge clk);
        checkOutput("second_req_ignored", 32'(bus.dump_valid), 0);

        // Abort a dump with reset at index 12
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
        cycles = 0;
        while (!(bus.dump_valid && (bus.dump_index == 5'd12)) && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("abort_reached_index12", 32'(bus.dump_index), 12);
        #2;
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_regs[i] = '0;
        end
        #1;
        checkOutput("abort_dump_valid", 32'(bus.dump_valid), 0);
        checkOutput("abort_dump_busy",  32'(bus.dump_busy),  0);
        checkOutput("abort_dump_index", 32'(bus.dump_index), 0);
        checkOutput("abort_dump_done",  32'(bus.dump_done),  0);
        checkFrf("abort");
        @(negedge clk);
        rst = 1'b0;
        done_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dump_done) begin
                done_count++;
            end
        end
        checkOutput("abort_no_done_pulse", 32'(done_count), 0);

        // Restart after abort begins again at index 0
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
        checkOutput("restart_valid", 32'(bus.dump_valid), 1);
        checkOutput("restart_index", 32'(bus.dump_index), 0);
        checkOutput("restart_data",  bus.dump_data,       0);
        cycles = 0;
        while (!bus.dump_done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("restart_done", 32'(bus.dump_done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the CPU register file.
- Configurable data width, register count and number of read ports.
- Two write ports with defined collision priority, plus an optional hardwired zero register.
- A sequential debug-dump engine streams every register out, one per cycle, to the synthesis-rig monitor without stalling the core's read/write ports.

Parameters:
- N, 32, data width in bits.
- A, 5, address width; DEPTH = 2**A registers.
- NR, 2, number of read ports (1..4).
- HARDWIRE_ZERO, 1, when 1 register 0 reads 0 and ignores writes.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NR*A  packed read addresses; port p = bits [p*A +: A].
- rd_data  output  NR*N  packed read data; port p = bits [p*N +: N]; combinational.
- wr_addr0  input  A  write port 0 address.
- wr_data0  input  N  write port 0 data.
- wr_ena0  input  1  write port 0 enable.
- wr_addr1  input  A  write port 1 address.
- wr_data1  input  N  write port 1 data.
- wr_ena1  input  1  write port 1 enable.
- dump_req  input  1  single-cycle pulse starting a dump.
- dump_busy  output  1  high while the dump engine is active.
- dump_valid  output  1  dump_index/dump_data valid this cycle.
- dump_index  output  A  register number being dumped.
- dump_data  output  N  contents of register dump_index.
- dump_done  output  1  one-cycle pulse after the last word.
- full_register_file  output  DEPTH*N  flattened state; reg i = bits [i*N +: N].

Behaviour:
- Reset (async, rst=1): all registers 0; dump FSM to IDLE.
  - dump_busy, dump_valid, dump_done = 0; dump_index = 0.
  - Writes are blocked while rst is high.
- Writes:
  - On posedge, reg[wr_addrX] <= wr_dataX when wr_enaX is high.
  - Both ports enabled to the same address: port 1 wins.
  - Different addresses: both written in the same cycle.
  - HARDWIRE_ZERO=1: writes to address 0 are discarded on both ports, and rd_data/dump_data/full_register_file show 0 for register 0.
- Reads:
  - Combinational from current register contents; one-cycle write-to-read latency unless REGFILE_BYPASS_EN is defined.
  - Any address in 0..DEPTH-1 is legal; there is no out-of-range case.
- Dump FSM, states IDLE -> RUN -> DONE -> IDLE:
  - IDLE: dump_req=1 at posedge -> RUN with dump_index=0, dump_valid=1, dump_busy=1.
  - RUN: each cycle presents dump_data = reg[dump_index] (current contents, never bypassed).
    - On posedge, dump_index increments.
    - When dump_index==DEPTH-1 at posedge -> DONE with dump_valid=0.
    - Exactly DEPTH valid cycles in total.
  - DONE: dump_done=1 for one cycle, dump_busy=1; then IDLE with dump_busy=0.
  - dump_req while in RUN or DONE is ignored (not queued).
  - dump_index wrap: never increments past DEPTH-1; returns to 0 in IDLE.
  - Writes during a dump proceed normally. A word not yet dumped shows its new value; a word already dumped is not re-emitted.
  - rst asserted mid-dump: immediate IDLE, all dump outputs 0, no dump_done pulse.
- Width rules: no sign extension or arithmetic; data is stored verbatim as N bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled same-cycle write returns that write's data combinationally (write-first).
  - If both ports match, port 1 data is returned.
  - Address 0 with HARDWIRE_ZERO=1 still returns 0.
  - full_register_file and dump_data are not bypassed.
- Undefined: reads return pre-write contents; new data is visible the cycle after the write.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with regs loaded -> full_register_file becomes all 0 before the next posedge; dump_busy=0.
- Dual write: wr_addr0=5, wr_data0=32'hAAAA0000, wr_addr1=6, wr_data1=32'h0000BBBB, both enabled -> next cycle rd_addr={6,5} gives rd_data={32'h0000BBBB,32'hAAAA0000}.
- Collision and zero register:
  - Both ports write addr 9 (port0=32'h1, port1=32'h2) -> reg9=32'h2.
  - Write 32'hFFFFFFFF to addr 0 -> reads 0.
- Bypass: write 32'hDEADBEEF to addr 3 while rd_addr port0=3.
  - With REGFILE_BYPASS_EN: rd_data port0=32'hDEADBEEF in the same cycle.
  - Without: old value, then 32'hDEADBEEF the next cycle.
- Dump: preload reg i = i*3, pulse dump_req -> DEPTH consecutive dump_valid cycles with index 0..31 and data 0,3,..,93, then one dump_done cycle.
  - A second dump_req at index 10 is ignored.
- Dump abort: assert rst at dump_index=12 -> dump_valid, dump_busy and dump_index go 0 immediately; no dump_done pulse; a new dump_req afterwards restarts at index 0.
